// File: rtl/adcreader_if.sv
// Bundles the start/sample handshake with the 3-wire ADC serial pins.
// master = capture engine side, slave = ADC plus sample consumer side.
interface adcreader_if #(
  parameter int DATA_BITS = 14
);
  logic                 start;
  logic                 sdata;
  logic                 sclk;
  logic                 cs_n;
  logic                 busy;
  logic [DATA_BITS-1:0] adc_data;
  logic                 valid;

  modport master (
    input  start,
    input  sdata,
    output sclk,
    output cs_n,
    output busy,
    output adc_data,
    output valid
  );

  modport slave (
    output start,
    output sdata,
    input  sclk,
    input  cs_n,
    input  busy,
    input  adc_data,
    input  valid
  );
endinterface

// File: rtl/adcreader.sv
// Serial ADC capture (CPOL=1, MSB first); valid at HALF_PERIOD*(2T+1)+1 cycles after start is accepted.
// No backpressure: start is only accepted while busy is low and is never queued.
module adcreader #(
  parameter int DATA_BITS    = 14,
  parameter int LEAD_BITS    = 2,
  parameter int HALF_PERIOD  = 1,
  parameter int QUIET_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  adcreader_if.master  bus
);
  localparam int T = LEAD_BITS + DATA_BITS;
  localparam logic [7:0] HP_LOAD = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] Q_LOAD  = 8'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);
  localparam logic [4:0] LAST_BIT = 5'(T - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t               state, state_nxt;
  logic [7:0]           hp_cnt, hp_nxt;
  logic [4:0]           bit_cnt, bit_nxt;
  logic [7:0]           q_cnt, q_nxt;
  logic [T-1:0]         shreg, sh_nxt;
  logic                 sclk_q, sclk_nxt;
  logic                 cs_n_q, cs_n_nxt;
  logic                 busy_q, busy_nxt;
  logic                 valid_q, valid_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hp_cnt  <= '0;
      bit_cnt <= '0;
      q_cnt   <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      hp_cnt  <= hp_nxt;
      bit_cnt <= bit_nxt;
      q_cnt   <= q_nxt;
      shreg   <= sh_nxt;
      sclk_q  <= sclk_nxt;
      cs_n_q  <= cs_n_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hp_nxt    = hp_cnt;
    bit_nxt   = bit_cnt;
    q_nxt     = q_cnt;
    sh_nxt    = shreg;
    sclk_nxt  = sclk_q;
    cs_n_nxt  = cs_n_q;
    busy_nxt  = busy_q;
    valid_nxt = 1'b0;
    data_nxt  = data_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          sclk_nxt  = 1'b1;
          hp_nxt    = HP_LOAD;
        end
      end
      SETUP: begin
        if (hp_cnt == '0) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b0;
          hp_nxt    = HP_LOAD;
          bit_nxt   = '0;
        end else begin
          hp_nxt = hp_cnt - 8'd1;
        end
      end
      SHIFT: begin
        if (hp_cnt != '0) begin
          hp_nxt = hp_cnt - 8'd1;
        end else begin
          hp_nxt = HP_LOAD;
          if (!sclk_q) begin
            // Rising sclk edge: the ADC has held this bit for a full low phase.
            sclk_nxt = 1'b1;
            sh_nxt   = {shreg[T-2:0], bus.sdata};
          end else if (bit_cnt == LAST_BIT) begin
            state_nxt = QUIET;
            cs_n_nxt  = 1'b1;
            sclk_nxt  = 1'b1;
            valid_nxt = 1'b1;
            data_nxt  = shreg[DATA_BITS-1:0];
            q_nxt     = Q_LOAD;
          end else begin
            sclk_nxt = 1'b0;
            bit_nxt  = bit_cnt + 5'd1;
          end
        end
      end
      QUIET: begin
        if (q_cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          q_nxt = q_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.adc_data = data_q;
endmodule

// File: tb/tb_adcreader.sv
// Randomized bench for adcreader: two instances (HALF_PERIOD 1 and 3) driven by a serial ADC model,
// checked cycle by cycle against timing derived from the conversion formulas.
module tb_adcreader;
  localparam int DB = 14;
  localparam int LB = 2;
  localparam int T  = DB + LB;
  localparam int Q  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adcreader_if #(.DATA_BITS(DB)) bus1 ();
  adcreader_if #(.DATA_BITS(DB)) bus3 ();

  adcreader #(.DATA_BITS(DB), .LEAD_BITS(LB), .HALF_PERIOD(1), .QUIET_CYCLES(Q))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  adcreader #(.DATA_BITS(DB), .LEAD_BITS(LB), .HALF_PERIOD(3), .QUIET_CYCLES(Q))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ADC model: presents the next word bit on each falling sclk while selected.
  logic [T-1:0] word1, word3;
  int idx1, idx3;
  always @(negedge bus1.cs_n) idx1 = 0;
  always @(negedge bus3.cs_n) idx3 = 0;
  always @(negedge bus1.sclk) if (!bus1.cs_n && idx1 < T) begin bus1.sdata = word1[T-1-idx1]; idx1++; end
  always @(negedge bus3.sclk) if (!bus3.cs_n && idx3 < T) begin bus3.sdata = word3[T-1-idx3]; idx3++; end

  task automatic sample(input int h, output logic cs, output logic sc, output logic bs,
                        output logic vl, output logic [DB-1:0] d);
    if (h == 1) begin cs = bus1.cs_n; sc = bus1.sclk; bs = bus1.busy; vl = bus1.valid; d = bus1.adc_data; end
    else        begin cs = bus3.cs_n; sc = bus3.sclk; bs = bus3.busy; vl = bus3.valid; d = bus3.adc_data; end
  endtask

  task automatic set_start(input int h, input logic v);
    if (h == 1) bus1.start = v; else bus3.start = v;
  endtask

  // Expected pin values in cycle n after the accepting edge (cycle 0).
  task automatic expect_at(input int n, input int h, output logic e_cs, output logic e_sc,
                           output logic e_bs, output logic e_vl);
    int v, m;
    v    = h * (2 * T + 1) + 1;
    e_cs = !(n >= 1 && n < v);
    e_bs = (n >= 1 && n < v + Q);
    e_vl = (n == v);
    e_sc = 1'b1;
    if (n > h && n < v) begin
      m    = n - 1 - h;
      e_sc = ((m % (2 * h)) >= h);
    end
  endtask

  // One full conversion with per-cycle pin checks; optional ignored re-starts at cycles 10 and 35.
  task automatic conv(input int h, input logic [T-1:0] word, input bit repulse, input string name);
    logic cs, sc, bs, vl, e_cs, e_sc, e_bs, e_vl, prev_sc;
    logic [DB-1:0] d;
    int v, rises;
    v = h * (2 * T + 1) + 1;
    if (h == 1) word1 = word; else word3 = word;
    rises   = 0;
    prev_sc = 1'b1;
    set_start(h, 1'b1);
    @(negedge clk);
    for (int n = 1; n <= v + Q + 1; n++) begin
      set_start(h, repulse && (n == 10 || n == 35));
      sample(h, cs, sc, bs, vl, d);
      expect_at(n, h, e_cs, e_sc, e_bs, e_vl);
      chk($sformatf("%s cs_n@%0d", name, n), 32'(cs), 32'(e_cs));
      chk($sformatf("%s sclk@%0d", name, n), 32'(sc), 32'(e_sc));
      chk($sformatf("%s busy@%0d", name, n), 32'(bs), 32'(e_bs));
      chk($sformatf("%s valid@%0d", name, n), 32'(vl), 32'(e_vl));
      if (n == v) chk($sformatf("%s data", name), 32'(d), 32'(word[DB-1:0]));
      if (!prev_sc && sc && !cs) rises++;
      prev_sc = sc;
      @(negedge clk);
    end
    set_start(h, 1'b0);
    chk($sformatf("%s rises", name), 32'(rises), 32'(T));
    sample(h, cs, sc, bs, vl, d);
    chk($sformatf("%s hold", name), 32'(d), 32'(word[DB-1:0]));
  endtask

  initial begin
    logic [T-1:0] w;
    logic [DB-1:0] keep;
    int vcyc[$];
    int run, seen_low, exp_v, period, wait_n;
    logic [DB-1:0] pats [4];
    pats = '{14'h3FFF, 14'h0000, 14'h2AAA, 14'h1555};

    reset = 1'b1;
    bus1.start = 1'b0; bus3.start = 1'b0;
    bus1.sdata = 1'b0; bus3.sdata = 1'b0;
    word1 = '0; word3 = '0;
    repeat (3) @(negedge clk);
    chk("rst cs_n", 32'(bus1.cs_n), 32'd1);
    chk("rst sclk", 32'(bus1.sclk), 32'd1);
    chk("rst busy", 32'(bus1.busy), 32'd0);
    chk("rst valid", 32'(bus1.valid), 32'd0);
    chk("rst data", 32'(bus1.adc_data), 32'd0);
    chk("rst3 cs_n", 32'(bus3.cs_n), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    conv(1, {2'b00, 14'h2A5B}, 1'b0, "basic");
    foreach (pats[i]) conv(1, {2'b11, pats[i]}, 1'b0, $sformatf("pat%0d", i));
    for (int i = 0; i < 6; i++) conv(1, T'($urandom), 1'b0, $sformatf("rnd%0d", i));

    w = T'($urandom);
    conv(1, w, 1'b1, "repulse");
    repeat (10) @(negedge clk);
    chk("repulse no valid", 32'(bus1.valid), 32'd0);
    chk("repulse idle", 32'(bus1.busy), 32'd0);
    chk("repulse data", 32'(bus1.adc_data), 32'(w[DB-1:0]));

    // Reset at cycle 20 of a conversion.
    word1 = T'($urandom);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort cs_n", 32'(bus1.cs_n), 32'd1);
    chk("abort sclk", 32'(bus1.sclk), 32'd1);
    chk("abort busy", 32'(bus1.busy), 32'd0);
    chk("abort data", 32'(bus1.adc_data), 32'd0);
    run = 0;
    for (int n = 0; n < 40; n++) begin
      run += int'(bus1.valid);
      @(negedge clk);
    end
    chk("abort valids", 32'(run), 32'd0);
    conv(1, T'($urandom), 1'b0, "after_rst");

    // Start held high: valid on a fixed period, cs_n high Q+1 cycles between conversions.
    word1 = T'($urandom);
    keep  = word1[DB-1:0];
    bus1.start = 1'b1;
    @(negedge clk);
    run = 0; seen_low = 0;
    for (int n = 1; n <= 200; n++) begin
      if (bus1.valid) begin
        vcyc.push_back(n);
        chk($sformatf("cont data@%0d", n), 32'(bus1.adc_data), 32'(keep));
      end
      if (bus1.cs_n) run++;
      else begin
        if (seen_low != 0 && run != 0) chk($sformatf("cont gap@%0d", n), 32'(run), 32'(Q + 1));
        seen_low = 1;
        run = 0;
      end
      @(negedge clk);
    end
    bus1.start = 1'b0;
    exp_v  = 2 * T + 2;
    period = exp_v + Q;
    chk("cont count", 32'(vcyc.size()), 32'((200 - exp_v) / period + 1));
    foreach (vcyc[i]) chk($sformatf("cont valid%0d", i), 32'(vcyc[i]), 32'(exp_v + i * period));
    wait_n = 0;
    while (bus1.busy && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    chk("cont drain", 32'(bus1.busy), 32'd0);
    @(negedge clk);

    conv(3, {2'b10, 14'h1234}, 1'b0, "h3");
    conv(3, T'($urandom), 1'b0, "h3rnd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
